// File: rtl/uart_tx_param.sv
// UART transmitter on the system clock with a bit-period counter and a valid/ready input.
// It supports runtime baud divisor, none/odd/even/mark parity and one or two stop bits.
module uart_tx_param #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        parity_type,
    input  logic              two_stop,
    input  logic [DIV_W-1:0]  baud_div,
    output logic              data_tx,
    output logic              active_flag,
    output logic              done_flag
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_q;
    logic [DIV_W-1:0]  tick_q;
    logic [DIV_W-1:0]  tick_d;
    logic [DIV_W-1:0]  div_q;
    logic [CNT_W-1:0]  bit_q;
    logic [DATA_W-1:0] shift_q;
    logic              par_bit_q;
    logic [1:0]        par_type_q;
    logic              two_stop_q;
    logic              stop2_q;
    logic              data_tx_q;
    logic              active_q;
    logic              done_q;
    logic              par_calc;
    logic              bit_end;

    always_comb begin
        par_calc = 1'b0;
        case (parity_type)
            2'b01:   par_calc = ~^data_in;
            2'b10:   par_calc = ^data_in;
            2'b11:   par_calc = 1'b1;
            default: par_calc = 1'b0;
        endcase
    end

    // The tick counter wraps on the last cycle of every bit, so it is already 0 in IDLE.
    assign bit_end = (tick_q == div_q);
    assign tick_d  = bit_end ? '0 : tick_q + DIV_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            par_type_q <= 2'b00;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
            data_tx_q  <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        shift_q    <= data_in;
                        par_bit_q  <= par_calc;
                        par_type_q <= parity_type;
                        two_stop_q <= two_stop;
                        div_q      <= baud_div;
                        tick_q     <= '0;
                        bit_q      <= '0;
                        stop2_q    <= 1'b0;
                        data_tx_q  <= 1'b0;
                        active_q   <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    tick_q <= tick_d;
                    if (bit_end) begin
                        data_tx_q <= shift_q[0];
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    tick_q <= tick_d;
                    if (bit_end) begin
                        if (bit_q == LAST_BIT) begin
                            if (par_type_q != 2'b00) begin
                                data_tx_q <= par_bit_q;
                                state_q   <= PARITY;
                            end else begin
                                data_tx_q <= 1'b1;
                                state_q   <= STOP;
                            end
                        end else begin
                            bit_q     <= bit_q + CNT_W'(1);
                            shift_q   <= shift_q >> 1;
                            data_tx_q <= shift_q[1];
                        end
                    end
                end
                PARITY: begin
                    tick_q <= tick_d;
                    if (bit_end) begin
                        data_tx_q <= 1'b1;
                        state_q   <= STOP;
                    end
                end
                STOP: begin
                    tick_q <= tick_d;
                    if (bit_end) begin
                        if (two_stop_q && !stop2_q) begin
                            stop2_q <= 1'b1;
                        end else begin
                            active_q <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= IDLE;
                        end
                    end
                end
                default: begin
                    data_tx_q <= 1'b1;
                    active_q  <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready    = (state_q == IDLE);
    assign data_tx     = data_tx_q;
    assign active_flag = active_q;
    assign done_flag   = done_q;

endmodule
